// File: rtl/coil_pattern_player.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : coil_pattern_player
// Purpose  : Reads 32-bit pattern words from an Avalon-MM FIFO read slave
//            (zero read latency, waitrequest flow control) and drives each
//            word onto the coil outputs for DUR+1 clocks. One word is
//            prefetched so that consecutive words play with no gap cycles.
//            Word format: [31] LAST, [30:16] DUR, [COIL_W-1:0] coil bits.
// Ports    : pd_clk_clk        - clock
//            pd_reset_reset_n  - asynchronous active-low reset
//            enable            - level, 1 = play, 0 = stop / return to idle
//            clear_status      - pulse, clears underrun and words_played
//            fifo_read         - Avalon read request
//            fifo_readdata     - read data, valid in the accept cycle
//            fifo_waitrequest  - slave stall (also high while FIFO empty)
//            coil_out          - registered coil drive
//            coil_strobe       - pulse when a new word is applied
//            busy              - high in PRIME/PLAY/STARVED/DRAIN
//            done_pulse        - pulse when a LAST word completes
//            underrun          - sticky: next word missing when needed
//            words_played      - count of applied words (wrapping)
// Revision : 1.0 - initial release
// ============================================================================
module coil_pattern_player #(
    parameter int                COIL_W       = 16,
    parameter logic [COIL_W-1:0] IDLE_PATTERN = '0,
    parameter int                CNT_W        = 16
) (
    input  logic              pd_clk_clk,
    input  logic              pd_reset_reset_n,
    input  logic              enable,
    input  logic              clear_status,
    output logic              fifo_read,
    input  logic [31:0]       fifo_readdata,
    input  logic              fifo_waitrequest,
    output logic [COIL_W-1:0] coil_out,
    output logic              coil_strobe,
    output logic              busy,
    output logic              done_pulse,
    output logic              underrun,
    output logic [CNT_W-1:0]  words_played
);

    // Stored word: {LAST, DUR[14:0], coil bits}; bits [15:COIL_W] are dropped.
    localparam int WW = 16 + COIL_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRIME   = 3'd1,
        S_PLAY    = 3'd2,
        S_STARVED = 3'd3,
        S_DONE    = 3'd4,
        S_DRAIN   = 3'd5
    } state_t;

    state_t            state_q;
    logic [14:0]       cnt_q;
    logic              last_q;
    logic [WW-1:0]     buf_q;
    logic              buf_valid_q;
    logic [COIL_W-1:0] coil_q;
    logic              strobe_q;
    logic              done_q;
    logic              underrun_q;
    logic [CNT_W-1:0]  words_q;

    logic              accept;
    logic [WW-1:0]     word_src;
    logic [CNT_W-1:0]  words_d;
    logic              unused_rd_bits;

    assign unused_rd_bits = ^fifo_readdata[15:0];

    // The read request must react in the same cycle the buffer drains, so it
    // is decoded from registered state rather than registered itself.
    always_comb begin
        fifo_read = 1'b0;
        case (state_q)
            S_PRIME, S_STARVED, S_DRAIN: fifo_read = 1'b1;
            S_PLAY:                      fifo_read = !buf_valid_q && !last_q;
            default:                     fifo_read = 1'b0;
        endcase
    end

    assign accept = fifo_read && !fifo_waitrequest;

    // The buffer is only ever full in PLAY, so outside PLAY this always
    // selects the live read data (bypass path).
    assign word_src = buf_valid_q ? buf_q
                                  : {fifo_readdata[31:16], fifo_readdata[COIL_W-1:0]};

    // Clear takes effect first so a simultaneous increment yields 1.
    assign words_d = (clear_status ? {CNT_W{1'b0}} : words_q) + CNT_W'(1);

    assign busy = (state_q == S_PRIME) || (state_q == S_PLAY) ||
                  (state_q == S_STARVED) || (state_q == S_DRAIN);

    always_ff @(posedge pd_clk_clk or negedge pd_reset_reset_n) begin
        if (!pd_reset_reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            coil_q      <= IDLE_PATTERN;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            words_q     <= '0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            if (clear_status) begin
                underrun_q <= 1'b0;
                words_q    <= '0;
            end
            if (cnt_q != 15'd0) begin
                cnt_q <= cnt_q - 15'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_PRIME;
                    end
                end

                S_PRIME, S_STARVED: begin
                    if (!enable) begin
                        coil_q      <= IDLE_PATTERN;
                        buf_valid_q <= 1'b0;
                        // Read is always pending here; a stalled one must be
                        // completed before leaving.
                        state_q     <= fifo_waitrequest ? S_DRAIN : S_IDLE;
                    end else if (accept) begin
                        coil_q   <= word_src[COIL_W-1:0];
                        cnt_q    <= word_src[COIL_W +: 15];
                        last_q   <= word_src[WW-1];
                        strobe_q <= 1'b1;
                        words_q  <= words_d;
                        state_q  <= S_PLAY;
                    end
                end

                S_PLAY: begin
                    if (!enable) begin
                        coil_q      <= IDLE_PATTERN;
                        buf_valid_q <= 1'b0;
                        state_q     <= (fifo_read && fifo_waitrequest) ? S_DRAIN : S_IDLE;
                    end else begin
                        if (accept && (cnt_q != 15'd0)) begin
                            buf_q       <= {fifo_readdata[31:16], fifo_readdata[COIL_W-1:0]};
                            buf_valid_q <= 1'b1;
                        end
                        if (cnt_q == 15'd0) begin
                            if (last_q) begin
                                coil_q  <= IDLE_PATTERN;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else if (buf_valid_q || accept) begin
                                coil_q      <= word_src[COIL_W-1:0];
                                cnt_q       <= word_src[COIL_W +: 15];
                                last_q      <= word_src[WW-1];
                                strobe_q    <= 1'b1;
                                words_q     <= words_d;
                                buf_valid_q <= 1'b0;
                            end else begin
                                coil_q     <= IDLE_PATTERN;
                                underrun_q <= 1'b1;
                                state_q    <= S_STARVED;
                            end
                        end
                    end
                end

                S_DONE: begin
                    if (!enable) begin
                        state_q <= S_IDLE;
                    end
                end

                S_DRAIN: begin
                    if (accept) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign coil_out     = coil_q;
    assign coil_strobe  = strobe_q;
    assign done_pulse   = done_q;
    assign underrun     = underrun_q;
    assign words_played = words_q;

endmodule
`default_nettype wire

// File: tb/tb_coil_pattern_player.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_coil_pattern_player
// Purpose  : Directed self-checking bench for coil_pattern_player with a
//            small FIFO slave model; a second narrow instance covers
//            IDLE_PATTERN, ignored coil bits and counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coil_pattern_player;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        enable;
    logic        clear_status;
    logic        stall;
    logic        fifo_read;
    logic [31:0] fifo_readdata;
    logic        fifo_waitrequest;
    logic [15:0] coil_out;
    logic        coil_strobe;
    logic        busy;
    logic        done_pulse;
    logic        underrun;
    logic [15:0] words_played;

    // FIFO slave model
    logic [31:0] mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    assign fifo_waitrequest = stall || (rd_ptr == wr_ptr);
    assign fifo_readdata    = mem[rd_ptr[5:0]];
    always @(posedge clk) if (fifo_read && !fifo_waitrequest) rd_ptr <= rd_ptr + 1;

    coil_pattern_player dut (
        .pd_clk_clk       (clk),
        .pd_reset_reset_n (rst_n),
        .enable           (enable),
        .clear_status     (clear_status),
        .fifo_read        (fifo_read),
        .fifo_readdata    (fifo_readdata),
        .fifo_waitrequest (fifo_waitrequest),
        .coil_out         (coil_out),
        .coil_strobe      (coil_strobe),
        .busy             (busy),
        .done_pulse       (done_pulse),
        .underrun         (underrun),
        .words_played     (words_played)
    );

    // Narrow instance: endless supply of {0,DUR=0,0xABCD}, rationed by give2
    logic        enable2;
    logic        clear2;
    logic        rd2;
    logic        wait2;
    logic [7:0]  coil2;
    logic        strobe2, busy2, done2, urun2;
    logic [3:0]  wp2;
    int          give2 = 0;
    int          took2 = 0;
    assign wait2 = (took2 >= give2);
    always @(posedge clk) if (rd2 && !wait2) took2 <= took2 + 1;

    coil_pattern_player #(.COIL_W(8), .IDLE_PATTERN(8'h3C), .CNT_W(4)) dut2 (
        .pd_clk_clk       (clk),
        .pd_reset_reset_n (rst_n),
        .enable           (enable2),
        .clear_status     (clear2),
        .fifo_read        (rd2),
        .fifo_readdata    (32'h0000_ABCD),
        .fifo_waitrequest (wait2),
        .coil_out         (coil2),
        .coil_strobe      (strobe2),
        .busy             (busy2),
        .done_pulse       (done2),
        .underrun         (urun2),
        .words_played     (wp2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // {coil, strobe, done, busy, underrun, fifo_read}
    function automatic logic [31:0] ev(input logic [15:0] c, input logic s, input logic d,
                                       input logic b, input logic u, input logic r);
        return {11'd0, c, s, d, b, u, r};
    endfunction

    function automatic logic [31:0] obs();
        return {11'd0, coil_out, coil_strobe, done_pulse, busy, underrun, fifo_read};
    endfunction

    function automatic logic [31:0] wd(input logic last, input logic [14:0] dur, input logic [15:0] c);
        return {last, dur, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc(input string tag, input logic [31:0] want);
        tick();
        check(tag, obs(), want);
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; clear_status = 1'b0; stall = 1'b0;
        enable2 = 1'b0; clear2 = 1'b0;
        @(negedge clk); @(negedge clk);
        check("reset_outs", obs(), ev(16'h0000, 0, 0, 0, 0, 0));
        check("reset_wp", {16'd0, words_played}, 32'd0);
        check("reset_idle2", {24'd0, coil2}, 32'h3C);
        rst_n = 1'b1;
        cyc("post_reset_idle", ev(16'h0000, 0, 0, 0, 0, 0));

        // Three words back-to-back
        push(wd(1'b0, 15'd2, 16'h00A5));
        push(wd(1'b0, 15'd0, 16'h5A00));
        push(wd(1'b1, 15'd1, 16'hFFFF));
        enable = 1'b1;
        cyc("t1_prime", ev(16'h0000, 0, 0, 1, 0, 1));
        cyc("t1_a0",    ev(16'h00A5, 1, 0, 1, 0, 1));
        cyc("t1_a1",    ev(16'h00A5, 0, 0, 1, 0, 0));
        cyc("t1_a2",    ev(16'h00A5, 0, 0, 1, 0, 0));
        cyc("t1_b0",    ev(16'h5A00, 1, 0, 1, 0, 1));
        cyc("t1_c0",    ev(16'hFFFF, 1, 0, 1, 0, 0));
        cyc("t1_c1",    ev(16'hFFFF, 0, 0, 1, 0, 0));
        cyc("t1_done",  ev(16'h0000, 0, 1, 0, 0, 0));
        cyc("t1_hold",  ev(16'h0000, 0, 0, 0, 0, 0));
        check("t1_wp", {16'd0, words_played}, 32'd3);
        enable = 1'b0;
        cyc("t1_idle", ev(16'h0000, 0, 0, 0, 0, 0));

        // Underrun then late word
        pulse_clear();
        check("t2_cleared_wp", {16'd0, words_played}, 32'd0);
        push(wd(1'b0, 15'd3, 16'h0001));
        enable = 1'b1;
        cyc("t2_prime", ev(16'h0000, 0, 0, 1, 0, 1));
        cyc("t2_d0",    ev(16'h0001, 1, 0, 1, 0, 1));
        for (int i = 0; i < 3; i++) cyc("t2_dn", ev(16'h0001, 0, 0, 1, 0, 1));
        for (int i = 0; i < 9; i++) cyc("t2_starved", ev(16'h0000, 0, 0, 1, 1, 1));
        push(wd(1'b1, 15'd0, 16'h0002));
        cyc("t2_e0",   ev(16'h0002, 1, 0, 1, 1, 0));
        cyc("t2_done", ev(16'h0000, 0, 1, 0, 1, 0));
        check("t2_wp", {16'd0, words_played}, 32'd2);
        enable = 1'b0;
        tick();

        // Drop enable while a read is stalled
        pulse_clear();
        check("t3_cleared", obs(), ev(16'h0000, 0, 0, 0, 0, 0));
        stall = 1'b1;
        push(wd(1'b0, 15'd5, 16'h1234));
        enable = 1'b1;
        cyc("t3_prime0", ev(16'h0000, 0, 0, 1, 0, 1));
        cyc("t3_prime1", ev(16'h0000, 0, 0, 1, 0, 1));
        enable = 1'b0;
        cyc("t3_drain0", ev(16'h0000, 0, 0, 1, 0, 1));
        cyc("t3_drain1", ev(16'h0000, 0, 0, 1, 0, 1));
        stall = 1'b0;
        cyc("t3_idle", ev(16'h0000, 0, 0, 0, 0, 0));
        check("t3_consumed", rd_ptr, wr_ptr);
        check("t3_wp", {16'd0, words_played}, 32'd0);

        // Next word arrives exactly in the counter==0 cycle
        push(wd(1'b0, 15'd2, 16'h0011));
        enable = 1'b1;
        cyc("t4_prime", ev(16'h0000, 0, 0, 1, 0, 1));
        cyc("t4_g0",    ev(16'h0011, 1, 0, 1, 0, 1));
        cyc("t4_g1",    ev(16'h0011, 0, 0, 1, 0, 1));
        cyc("t4_g2",    ev(16'h0011, 0, 0, 1, 0, 1));
        push(wd(1'b1, 15'd0, 16'h0022));
        cyc("t4_h0",    ev(16'h0022, 1, 0, 1, 0, 0));
        cyc("t4_done",  ev(16'h0000, 0, 1, 0, 0, 0));
        check("t4_wp", {16'd0, words_played}, 32'd2);
        enable = 1'b0;
        tick();

        // clear_status coinciding with underrun set, then with an increment
        pulse_clear();
        push(wd(1'b0, 15'd0, 16'h0003));
        enable = 1'b1;
        cyc("t6_prime", ev(16'h0000, 0, 0, 1, 0, 1));
        cyc("t6_w0",    ev(16'h0003, 1, 0, 1, 0, 1));
        clear_status = 1'b1;
        cyc("t6_urun_wins", ev(16'h0000, 0, 0, 1, 1, 1));
        check("t6_wp_cleared", {16'd0, words_played}, 32'd0);
        push(wd(1'b1, 15'd0, 16'h0004));
        cyc("t6_w1", ev(16'h0004, 1, 0, 1, 0, 0));
        clear_status = 1'b0;
        check("t6_wp_clr_inc", {16'd0, words_played}, 32'd1);
        cyc("t6_done", ev(16'h0000, 0, 1, 0, 0, 0));
        enable = 1'b0;
        tick();

        // Asynchronous reset in the middle of playback
        push(wd(1'b0, 15'd20, 16'hFFFF));
        enable = 1'b1;
        cyc("t5_prime", ev(16'h0000, 0, 0, 1, 0, 1));
        cyc("t5_play",  ev(16'hFFFF, 1, 0, 1, 0, 1));
        #2 rst_n = 1'b0;
        #1 check("t5_async", obs(), ev(16'h0000, 0, 0, 0, 0, 0));
        check("t5_wp", {16'd0, words_played}, 32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc("t5_idle0", ev(16'h0000, 0, 0, 0, 0, 0));
        cyc("t5_idle1", ev(16'h0000, 0, 0, 0, 0, 0));
        enable = 1'b1;
        cyc("t5_rearm", ev(16'h0000, 0, 0, 1, 0, 1));
        enable = 1'b0;
        cyc("t5_drain", ev(16'h0000, 0, 0, 1, 0, 1));
        push(wd(1'b0, 15'd0, 16'h7777));
        cyc("t5_drained", ev(16'h0000, 0, 0, 0, 0, 0));
        check("t5_wp_after", {16'd0, words_played}, 32'd0);

        // Narrow instance: 15 words, then one more to wrap the 4-bit counter
        give2 = 15;
        enable2 = 1'b1;
        repeat (25) tick();
        check("n_wp15", {28'd0, wp2}, 32'hF);
        check("n_idle_pat", {24'd0, coil2}, 32'h3C);
        check("n_underrun", {31'd0, urun2}, 32'd1);
        give2 = 16;
        tick();
        check("n_coil_bits", {24'd0, coil2}, 32'hCD);
        check("n_wrap", {28'd0, wp2}, 32'h0);
        tick();
        check("n_idle_again", {24'd0, coil2}, 32'h3C);
        enable2 = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
